tri_color_mode_ctrl: RTL

- Downstream consumer of the switch-detection stage.
- Takes the single-cycle debounced key event `fake_switch` and steps the three-colour LED through a fixed ring of display modes.
- Drives the R/G/B LED pins directly, including timed colour rotation and a PWM "breathing" effect.
- Sits between the switch-detection block and the board LED pins.

---
 rtl/tri_color_pkg.sv | 54 +++++
 rtl/tri_color_mode_ctrl_if.sv | 16 +
 rtl/pwm_gen.sv | 29 ++
 rtl/tri_color_mode_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/tri_color_pkg.sv
// Shared encodings and helpers for the tri-colour LED mode controller.
//   - mode_e : display-mode codes stepped by the switch event
//   - col_e  : colour index used by the timed colour rotation
//   - led_pins / mode_next / col_next : small combinational helpers
package tri_color_pkg;

   localparam int unsigned MODE_W = 3;
   localparam int unsigned COL_W  = 2;
   localparam int unsigned LED_W  = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF    = 3'd0,
      MODE_RED    = 3'd1,
      MODE_GREEN  = 3'd2,
      MODE_BLUE   = 3'd3,
      MODE_WHITE  = 3'd4,
      MODE_CYCLE  = 3'd5,
      MODE_BREATH = 3'd6
   } mode_e;

   typedef enum logic [COL_W-1:0] {
      COL_R = 2'd0,
      COL_G = 2'd1,
      COL_B = 2'd2
   } col_e;

   // Lit-mask {R,G,B} to pin levels for the board's LED polarity.
   function automatic logic [LED_W-1:0] led_pins(input logic [LED_W-1:0] lit,
                                                 input logic active_low);
      return active_low ? ~lit : lit;
   endfunction

   // Ring successor; any unnamed code falls back to OFF.
   function automatic mode_e mode_next(input mode_e m);
      case (m)
         MODE_OFF:    return MODE_RED;
         MODE_RED:    return MODE_GREEN;
         MODE_GREEN:  return MODE_BLUE;
         MODE_BLUE:   return MODE_WHITE;
         MODE_WHITE:  return MODE_CYCLE;
         MODE_CYCLE:  return MODE_BREATH;
         default:     return MODE_OFF;
      endcase
   endfunction

   function automatic col_e col_next(input col_e c);
      case (c)
         COL_R:   return COL_G;
         COL_G:   return COL_B;
         default: return COL_R;
      endcase
   endfunction

endpackage

// File: rtl/tri_color_mode_ctrl_if.sv
// Key-event / LED-pin bundle of the tri-colour mode controller.
//   fake_switch : one-cycle advance pulse (master -> slave)
//   mode        : current mode code (slave -> master)
//   LED_R/G/B   : LED pin levels (slave -> master)
interface tri_color_mode_ctrl_if;
   import tri_color_pkg::*;

   logic              fake_switch;
   logic [MODE_W-1:0] mode;
   logic              LED_R;
   logic              LED_G;
   logic              LED_B;

   modport master (output fake_switch, input mode, LED_R, LED_G, LED_B);
   modport slave  (input fake_switch, output mode, LED_R, LED_G, LED_B);
endinterface

// File: rtl/pwm_gen.sv
// Free-running PWM counter with duty compare.
//   Sys_CLK, Sys_RST : clock, synchronous active-high reset
//   clr              : hold counter at 0
//   duty             : on-time in counter ticks (0 = always off)
//   pwm_on           : high while counter < duty
module pwm_gen #(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                Sys_CLK,
   input  logic                Sys_RST,
   input  logic                clr,
   input  logic [PWM_BITS-1:0] duty,
   output logic                pwm_on
);

   logic [PWM_BITS-1:0] cnt_q;

   always_ff @(posedge Sys_CLK) begin
      if (Sys_RST || clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PWM_BITS'(1);
      end
   end

   // Compare against the registered count; the caller registers the result.
   assign pwm_on = (cnt_q < duty);

endmodule

// File: rtl/tri_color_mode_ctrl.sv
// Steps a tri-colour LED through OFF/RED/GREEN/BLUE/WHITE/CYCLE/BREATH on
// each key event and drives the pins, including timed colour rotation and
// a PWM breathing ramp.
//   Sys_CLK, Sys_RST : clock, synchronous active-high reset
//   bus (slave)      : fake_switch in; mode, LED_R/G/B out (all registered)
module tri_color_mode_ctrl
   import tri_color_pkg::*;
#(
   parameter int unsigned CYCLE_TICKS       = 50_000_000,
   parameter int unsigned BREATH_STEP_TICKS = 97_656,
   parameter int unsigned PWM_BITS          = 8,
   parameter int unsigned LED_ACTIVE_LOW    = 1
) (
   input  logic                 Sys_CLK,
   input  logic                 Sys_RST,
   tri_color_mode_ctrl_if.slave bus
);

   localparam int unsigned CYC_W = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
   localparam int unsigned BR_W  = (BREATH_STEP_TICKS > 1) ? $clog2(BREATH_STEP_TICKS) : 1;

   localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(CYCLE_TICKS - 1);
   localparam logic [BR_W-1:0]     BR_LAST  = BR_W'(BREATH_STEP_TICKS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic                ACT_LOW  = (LED_ACTIVE_LOW != 0);

   mode_e               mode_q;
   logic [CYC_W-1:0]    cyc_tmr_q;
   col_e                col_q;
   logic [BR_W-1:0]     br_tmr_q;
   logic [PWM_BITS-1:0] duty_q;
   logic                dir_up_q;
   logic [LED_W-1:0]    led_q;

   logic                pwm_on;
   logic                pwm_clr;
   logic [LED_W-1:0]    lit_c;

   // PWM counter only runs while settled in BREATH; a mode change reloads it.
   assign pwm_clr = bus.fake_switch || (mode_q != MODE_BREATH);

   pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
      .Sys_CLK (Sys_CLK),
      .Sys_RST (Sys_RST),
      .clr     (pwm_clr),
      .duty    (duty_q),
      .pwm_on  (pwm_on)
   );

   // Lit-mask {R,G,B} for the current mode.
   always_comb begin
      lit_c = 3'b000;
      case (mode_q)
         MODE_RED:    lit_c = 3'b100;
         MODE_GREEN:  lit_c = 3'b010;
         MODE_BLUE:   lit_c = 3'b001;
         MODE_WHITE:  lit_c = 3'b111;
         MODE_CYCLE: begin
            case (col_q)
               COL_R:   lit_c = 3'b100;
               COL_G:   lit_c = 3'b010;
               COL_B:   lit_c = 3'b001;
               default: lit_c = 3'b000;
            endcase
         end
         MODE_BREATH: lit_c = {LED_W{pwm_on}};
         default:     lit_c = 3'b000;
      endcase
   end

   // Mode register, colour-rotation timer, breathing ramp and pin register.
   always_ff @(posedge Sys_CLK) begin
      if (Sys_RST) begin
         mode_q    <= MODE_OFF;
         cyc_tmr_q <= '0;
         col_q     <= COL_R;
         br_tmr_q  <= '0;
         duty_q    <= '0;
         dir_up_q  <= 1'b1;
         led_q     <= led_pins(3'b000, ACT_LOW);
      end else begin
         // Pins follow mode by exactly one register stage.
         led_q <= led_pins(lit_c, ACT_LOW);

         if (bus.fake_switch) begin
            // Mode change beats any coincident timer wrap.
            mode_q    <= mode_next(mode_q);
            cyc_tmr_q <= '0;
            col_q     <= COL_R;
            br_tmr_q  <= '0;
            duty_q    <= '0;
            dir_up_q  <= 1'b1;
         end else begin
            if (mode_q == MODE_CYCLE) begin
               if (cyc_tmr_q == CYC_LAST) begin
                  cyc_tmr_q <= '0;
                  col_q     <= col_next(col_q);
               end else begin
                  cyc_tmr_q <= cyc_tmr_q + CYC_W'(1);
               end
            end else begin
               cyc_tmr_q <= '0;
               col_q     <= COL_R;
            end

            if (mode_q == MODE_BREATH) begin
               if (br_tmr_q == BR_LAST) begin
                  br_tmr_q <= '0;
                  // Direction flips on arrival at an extreme, so each
                  // extreme lasts one step and duty never wraps.
                  if (dir_up_q) begin
                     duty_q <= duty_q + PWM_BITS'(1);
                     if (duty_q == DUTY_MAX - PWM_BITS'(1)) begin
                        dir_up_q <= 1'b0;
                     end
                  end else begin
                     duty_q <= duty_q - PWM_BITS'(1);
                     if (duty_q == PWM_BITS'(1)) begin
                        dir_up_q <= 1'b1;
                     end
                  end
               end else begin
                  br_tmr_q <= br_tmr_q + BR_W'(1);
               end
            end else begin
               br_tmr_q <= '0;
               duty_q   <= '0;
               dir_up_q <= 1'b1;
            end
         end
      end
   end

   assign bus.mode  = MODE_W'(mode_q);
   assign bus.LED_R = led_q[2];
   assign bus.LED_G = led_q[1];
   assign bus.LED_B = led_q[0];

endmodule
